program_memory: RTL
===================

// Module: program_memory
// PURPOSE
//   Reloadable instruction store for the mini-CPU.
//   - Loaded at run time over a valid/ready word stream, then serves instruction fetches.
//   - Fetch has 1-cycle registered latency.
//   - Addresses that were never loaded, or that lie beyond the loaded program, return DEFAULT_INSTR.
//   - Sits between the boot/host interface and the fetch stage. iAddress is driven by the IP.
// PARAMETERS
//   DATA_WIDTH     28   instruction width in bits
//   ADDR_WIDTH     16   fetch address width in bits
//   DEPTH          64   number of storage words; must be >=2 and <= 2**ADDR_WIDTH
//   DEFAULT_INSTR  0    word returned for unloaded or out-of-range addresses (DATA_WIDTH bits)
//   CW = $clog2(DEPTH)+1 (derived)
// PORTS
//   Clock         in   1           rising-edge clock
//   Reset         in   1           asynchronous, active-low reset
//   iLoadStart    in   1           pulse: begin (re)loading a program
//   iLoadValid    in   1           iLoadData is valid this cycle
//   iLoadData     in   DATA_WIDTH  instruction word to store
//   iLoadLast     in   1           qualifies the final word of the program
//   oLoadReady    out  1           block accepts a load word this cycle
//   iAddress      in   ADDR_WIDTH  fetch address
//   oInstruction  out  DATA_WIDTH  fetched instruction, registered
//   oInstrValid   out  1           oInstruction is a valid fetch result
//   oLoadCount    out  CW          number of words in the loaded program
//   oLoadError    out  1           sticky: program overflowed DEPTH
// BEHAVIOUR
//   Reset (asynchronous, Reset==0)
//   - State=IDLE. oInstruction=DEFAULT_INSTR. oInstrValid=0, oLoadReady=0.
//   - oLoadCount=0, oLoadError=0, write pointer=0.
//   - Memory array is NOT cleared.
//   - Reset mid-load aborts the load. All addresses then read DEFAULT_INSTR until a new load completes.
//   FSM: IDLE -> LOAD -> RUN
//   - IDLE: oLoadReady=0, oInstrValid=0.
//     - iLoadStart=1 -> LOAD next cycle; pointer=0, oLoadCount=0, oLoadError=0.
//   - LOAD: oLoadReady=1.
//     - A word is accepted when iLoadValid & oLoadReady.
//     - On accept: mem[ptr] <= iLoadData; ptr++; oLoadCount++.
//     - Accepted word with iLoadLast=1 -> RUN next cycle.
//     - Accepted word at ptr==DEPTH-1 with iLoadLast=0 -> RUN; oLoadError<=1 (program truncated to DEPTH).
//     - iLoadStart is ignored while in LOAD.
//     - oInstrValid=0; oInstruction holds DEFAULT_INSTR.
//   - RUN: oLoadReady=0, oInstrValid=1.
//     - Each cycle: oInstruction <= (iAddress < oLoadCount) ? mem[iAddress] : DEFAULT_INSTR.
//     - Compare is unsigned, at full ADDR_WIDTH; no wrap-around.
//     - iLoadStart=1 -> LOAD next cycle; pointer and count clear; oInstrValid=0 from that next cycle.
//   Latency
//   - iAddress sampled at edge N appears on oInstruction after edge N.
//   - The first valid fetch is the edge after entering RUN.
//   oLoadCount saturates at DEPTH; its width is CW, so DEPTH itself is representable.
//   Data words are never dropped: when oLoadReady=0, iLoadValid has no effect.
// TESTING
//   1. Reset -> oInstruction=DEFAULT_INSTR, oInstrValid=0, oLoadReady=0, oLoadCount=0.
//   2. Load 40, 20, 7 (Last on 7); fetch addr 0,1,2,3
//      -> 40, 20, 7, DEFAULT one cycle later; oLoadCount=3.
//   3. Load with iLoadValid gapped (1 cycle on / 2 off)
//      -> same contents as scenario 2; no duplicate or missed writes.
//   4. DEPTH=64: stream 70 words with no Last
//      -> RUN after 64 words; oLoadError=1, oLoadCount=64; addr 63 = 64th word; addr 64 = DEFAULT.
//   5. In RUN, reload 2 words (99, 98)
//      -> addr 0,1 = 99, 98; addr 2 = DEFAULT (old word hidden); oLoadError cleared.
//   6. Assert Reset after 2 of 5 load words
//      -> IDLE immediately; oLoadCount=0; no RUN entry without a new iLoadStart.

Source files
------------

// File: rtl/program_memory.sv
// Reloadable instruction store: a valid/ready word stream loads the program,
// then the store serves registered fetches, returning DEFAULT_INSTR past the loaded length.
module program_memory #(
  parameter int                    DATA_WIDTH    = 28,
  parameter int                    ADDR_WIDTH    = 16,
  parameter int                    DEPTH         = 64,
  parameter logic [DATA_WIDTH-1:0] DEFAULT_INSTR = '0,
  localparam int                   CW            = $clog2(DEPTH) + 1
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  iLoadStart,
  input  logic                  iLoadValid,
  input  logic [DATA_WIDTH-1:0] iLoadData,
  input  logic                  iLoadLast,
  output logic                  oLoadReady,
  input  logic [ADDR_WIDTH-1:0] iAddress,
  output logic [DATA_WIDTH-1:0] oInstruction,
  output logic                  oInstrValid,
  output logic [CW-1:0]         oLoadCount,
  output logic                  oLoadError
);

  localparam int IW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  state_t                state_q, state_d;
  logic [IW-1:0]         ptr_q, ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] instr_q, instr_d;
  logic                  valid_q, valid_d;
  logic                  wr_en;
  logic                  in_range;
  logic [DATA_WIDTH-1:0] mem_rd;

  // Storage is deliberately left uninitialised; the loaded length gates every read.
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge Clock) begin
    if (wr_en) begin
      mem[ptr_q] <= iLoadData;
    end
  end

  assign mem_rd   = mem[iAddress[IW-1:0]];
  assign in_range = {1'b0, iAddress} < (ADDR_WIDTH + 1)'(count_q);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    count_d = count_q;
    err_d   = err_q;
    instr_d = DEFAULT_INSTR;
    valid_d = 1'b0;
    wr_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (iLoadStart) begin
          state_d = LOAD;
          ptr_d   = '0;
          count_d = '0;
          err_d   = 1'b0;
        end
      end
      LOAD: begin
        if (iLoadValid) begin
          wr_en   = 1'b1;
          ptr_d   = ptr_q + IW'(1);
          count_d = count_q + CW'(1);
          if (iLoadLast) begin
            state_d = RUN;
          end else if (ptr_q == IW'(DEPTH - 1)) begin
            // Full store without Last: keep what fits and flag the truncation.
            state_d = RUN;
            err_d   = 1'b1;
          end
        end
      end
      RUN: begin
        if (iLoadStart) begin
          state_d = LOAD;
          ptr_d   = '0;
          count_d = '0;
          err_d   = 1'b0;
        end else begin
          valid_d = 1'b1;
          instr_d = in_range ? mem_rd : DEFAULT_INSTR;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
      instr_q <= DEFAULT_INSTR;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      count_q <= count_d;
      err_q   <= err_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
    end
  end

  assign oLoadReady   = (state_q == LOAD);
  assign oInstruction = instr_q;
  assign oInstrValid  = valid_q;
  assign oLoadCount   = count_q;
  assign oLoadError   = err_q;

endmodule
